// File: rtl/multi_cycle_control_unit_if.sv
// Control bus between the multi-cycle sequencer and the datapath it steers.
// The sequencer is the master; the datapath supplies opcode/zero and consumes the strobes.
interface multi_cycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       IRWre;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       RegWre;
    logic       DataMemRW;
    logic [2:0] ALUOp;
    logic       ALUSrcB;
    logic       ExtSel;
    logic       RegOut;
    logic       ALUM2Reg;

    modport master (
        input  opcode, zero,
        output IRWre, PCWre, PCSrc, RegWre, DataMemRW,
        output ALUOp, ALUSrcB, ExtSel, RegOut, ALUM2Reg
    );

    modport slave (
        output opcode, zero,
        input  IRWre, PCWre, PCSrc, RegWre, DataMemRW,
        input  ALUOp, ALUSrcB, ExtSel, RegOut, ALUM2Reg
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle sequencer: walks each instruction through IF/ID/EXE/MEM/WB, fires write
// strobes only in the committing state, and counts retired instructions.
module multi_cycle_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    multi_cycle_control_unit_if.master  ctrl,
    output logic [3:0]                  state,
    output logic                        halted,
    output logic [CNT_W-1:0]            instr_count
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_WB_AL  = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_EXE_LS = 4'b0101,
        S_MEM    = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } stateT;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    stateT      curState, nextState;
    logic       isRType, isAluImm, isLoad, isStore, isBranch, isJump, isHalt;
    logic       irWre, pcWre, regWre, memWr;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
    logic       aluSrcB, extSel, regOut, aluM2Reg;

    assign isRType  = (ctrl.opcode == OP_ADD) || (ctrl.opcode == OP_SUB) ||
                      (ctrl.opcode == OP_AND) || (ctrl.opcode == OP_OR);
    assign isAluImm = (ctrl.opcode == OP_ADDI) || (ctrl.opcode == OP_ORI);
    assign isLoad   = (ctrl.opcode == OP_LW);
    assign isStore  = (ctrl.opcode == OP_SW);
    assign isBranch = (ctrl.opcode == OP_BEQ);
    assign isJump   = (ctrl.opcode == OP_J);
    assign isHalt   = (ctrl.opcode == OP_HALT);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) curState <= S_IF;
        else        curState <= nextState;
    end

    // NOTE: every output is defaulted before the case so no path can infer a latch.
    always_comb begin
        nextState = curState;
        irWre     = 1'b0;
        pcWre     = 1'b0;
        pcSrc     = 2'b00;
        regWre    = 1'b0;
        memWr     = 1'b0;
        case (curState)
            S_IF: begin
                irWre     = 1'b1;
                nextState = S_ID;
            end
            S_ID: begin
                if (isRType || isAluImm)     nextState = S_EXE_AL;
                else if (isLoad || isStore)  nextState = S_EXE_LS;
                else if (isBranch)           nextState = S_EXE_BR;
                else if (isHalt)             nextState = S_HALT;
                else begin
                    // j and unknown opcodes (NOP) retire here.
                    pcWre     = 1'b1;
                    pcSrc     = isJump ? 2'b10 : 2'b00;
                    nextState = S_IF;
                end
            end
            S_EXE_AL: nextState = S_WB_AL;
            S_WB_AL: begin
                pcWre     = 1'b1;
                regWre    = 1'b1;
                nextState = S_IF;
            end
            S_EXE_BR: begin
                pcWre     = 1'b1;
                pcSrc     = {1'b0, ctrl.zero};
                nextState = S_IF;
            end
            S_EXE_LS: nextState = S_MEM;
            S_MEM: begin
                if (isStore) begin
                    pcWre     = 1'b1;
                    memWr     = 1'b1;
                    nextState = S_IF;
                end else begin
                    nextState = S_WB_LD;
                end
            end
            S_WB_LD: begin
                pcWre     = 1'b1;
                regWre    = 1'b1;
                nextState = S_IF;
            end
            S_HALT:  nextState = S_HALT;
            default: nextState = S_IF;
        endcase
    end

    // Steering is decoded from the IR opcode, but forced quiet while fetching or halted.
    always_comb begin
        aluOp    = 3'b000;
        aluSrcB  = 1'b0;
        extSel   = 1'b0;
        regOut   = 1'b0;
        aluM2Reg = 1'b0;
        if (curState != S_IF && curState != S_HALT) begin
            case (ctrl.opcode)
                OP_ADD:  begin aluOp = 3'b000; regOut = 1'b1; end
                OP_SUB:  begin aluOp = 3'b001; regOut = 1'b1; end
                OP_AND:  begin aluOp = 3'b011; regOut = 1'b1; end
                OP_OR:   begin aluOp = 3'b010; regOut = 1'b1; end
                OP_ADDI: begin aluOp = 3'b000; extSel = 1'b1; aluSrcB = 1'b1; end
                OP_ORI:  begin aluOp = 3'b010; extSel = 1'b0; aluSrcB = 1'b1; end
                OP_SW:   begin aluOp = 3'b000; extSel = 1'b1; aluSrcB = 1'b1; end
                OP_LW:   begin aluOp = 3'b000; extSel = 1'b1; aluSrcB = 1'b1; aluM2Reg = 1'b1; end
                OP_BEQ:  begin aluOp = 3'b001; extSel = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     instr_count <= '0;
        else if (pcWre) instr_count <= instr_count + CNT_W'(1);
    end

    assign ctrl.IRWre     = irWre;
    assign ctrl.PCWre     = pcWre;
    assign ctrl.PCSrc     = pcSrc;
    assign ctrl.RegWre    = regWre;
    assign ctrl.DataMemRW = memWr;
    assign ctrl.ALUOp     = aluOp;
    assign ctrl.ALUSrcB   = aluSrcB;
    assign ctrl.ExtSel    = extSel;
    assign ctrl.RegOut    = regOut;
    assign ctrl.ALUM2Reg  = aluM2Reg;
    assign state          = curState;
    assign halted         = (curState == S_HALT);

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: per-cycle expected outputs are queued
// when an instruction is issued and compared each cycle while it executes.
module tb_multi_cycle_control_unit;

    localparam int CW = 8;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b101010;

    typedef struct {
        logic [3:0]    st;
        logic          irWre;
        logic          pcWre;
        logic [1:0]    pcSrc;
        logic          regWre;
        logic          memWr;
        logic [2:0]    aluOp;
        logic          aluSrcB;
        logic          extSel;
        logic          regOut;
        logic          aluM2Reg;
        logic          halted;
        logic [CW-1:0] cnt;
    } expT;

    logic          clk;
    logic          reset;
    logic [3:0]    state;
    logic          halted;
    logic [CW-1:0] instr_count;

    multi_cycle_control_unit_if busIf();

    multi_cycle_control_unit #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (busIf),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cycleNo = 0;
    logic [CW-1:0] expCount = '0;
    expT           sbQ[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: spec tables turned into one expected record per cycle.
    task automatic pushInstr(input logic [5:0] op, input logic z);
        logic [3:0] seq[$];
        logic       isR, isImm, isLs;
        expT        e;
        isR   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        isImm = (op == OP_ADDI) || (op == OP_ORI);
        isLs  = (op == OP_LW) || (op == OP_SW);
        seq.push_back(4'b0000);
        seq.push_back(4'b0001);
        if (isR || isImm) begin
            seq.push_back(4'b0010); seq.push_back(4'b0011);
        end else if (isLs) begin
            seq.push_back(4'b0101); seq.push_back(4'b0110);
            if (op == OP_LW) seq.push_back(4'b0111);
        end else if (op == OP_BEQ) begin
            seq.push_back(4'b0100);
        end else if (op == OP_HALT) begin
            for (int i = 0; i < 50; i++) seq.push_back(4'b1000);
        end
        foreach (seq[i]) begin
            e = '{st: seq[i], irWre: 1'b0, pcWre: 1'b0, pcSrc: 2'b00, regWre: 1'b0,
                  memWr: 1'b0, aluOp: 3'b000, aluSrcB: 1'b0, extSel: 1'b0, regOut: 1'b0,
                  aluM2Reg: 1'b0, halted: 1'b0, cnt: expCount};
            if (seq[i] != 4'b0000 && seq[i] != 4'b1000) begin
                case (op)
                    OP_SUB:  e.aluOp = 3'b001;
                    OP_AND:  e.aluOp = 3'b011;
                    OP_OR:   e.aluOp = 3'b010;
                    OP_ORI:  e.aluOp = 3'b010;
                    OP_BEQ:  e.aluOp = 3'b001;
                    default: e.aluOp = 3'b000;
                endcase
                e.aluSrcB  = isImm || isLs;
                e.extSel   = (op == OP_ADDI) || isLs || (op == OP_BEQ);
                e.regOut   = isR;
                e.aluM2Reg = (op == OP_LW);
            end
            case (seq[i])
                4'b0000: e.irWre = 1'b1;
                4'b0001: if (!(isR || isImm || isLs || op == OP_BEQ || op == OP_HALT)) begin
                    e.pcWre = 1'b1;
                    e.pcSrc = (op == OP_J) ? 2'b10 : 2'b00;
                end
                4'b0011, 4'b0111: begin e.pcWre = 1'b1; e.regWre = 1'b1; end
                4'b0100: begin e.pcWre = 1'b1; e.pcSrc = {1'b0, z}; end
                4'b0110: if (op == OP_SW) begin e.pcWre = 1'b1; e.memWr = 1'b1; end
                4'b1000: e.halted = 1'b1;
                default: ;
            endcase
            sbQ.push_back(e);
            if (e.pcWre) expCount = expCount + 1'b1;
        end
    endtask

    task automatic compare(input expT e);
        string p;
        p = $sformatf("c%0d.", cycleNo);
        check({p, "state"},     32'(state),           32'(e.st));
        check({p, "IRWre"},     32'(busIf.IRWre),     32'(e.irWre));
        check({p, "PCWre"},     32'(busIf.PCWre),     32'(e.pcWre));
        check({p, "PCSrc"},     32'(busIf.PCSrc),     32'(e.pcSrc));
        check({p, "RegWre"},    32'(busIf.RegWre),    32'(e.regWre));
        check({p, "DataMemRW"}, 32'(busIf.DataMemRW), 32'(e.memWr));
        check({p, "ALUOp"},     32'(busIf.ALUOp),     32'(e.aluOp));
        check({p, "ALUSrcB"},   32'(busIf.ALUSrcB),   32'(e.aluSrcB));
        check({p, "ExtSel"},    32'(busIf.ExtSel),    32'(e.extSel));
        check({p, "RegOut"},    32'(busIf.RegOut),    32'(e.regOut));
        check({p, "ALUM2Reg"},  32'(busIf.ALUM2Reg),  32'(e.aluM2Reg));
        check({p, "halted"},    32'(halted),          32'(e.halted));
        check({p, "count"},     32'(instr_count),     32'(e.cnt));
    endtask

    // Called at a falling edge with the DUT in IF; stopAfter > 0 leaves mid-instruction.
    task automatic runInstr(input logic [5:0] op, input logic z, input int stopAfter);
        expT e;
        int  n = 0;
        busIf.opcode = op;
        busIf.zero   = z;
        pushInstr(op, z);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            #1;
            compare(e);
            cycleNo++;
            n++;
            if (stopAfter != 0 && n == stopAfter) begin
                sbQ.delete();
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".state"},  32'(state),        32'd0);
        check({tag, ".IRWre"},  32'(busIf.IRWre),  32'd1);
        check({tag, ".PCWre"},  32'(busIf.PCWre),  32'd0);
        check({tag, ".RegWre"}, 32'(busIf.RegWre), 32'd0);
        check({tag, ".PCSrc"},  32'(busIf.PCSrc),  32'd0);
        check({tag, ".ALUOp"},  32'(busIf.ALUOp),  32'd0);
        check({tag, ".RegOut"}, 32'(busIf.RegOut), 32'd0);
        check({tag, ".halted"}, 32'(halted),       32'd0);
        check({tag, ".count"},  32'(instr_count),  32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        busIf.opcode = OP_ADD;
        busIf.zero   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkResetState("rst0");
        @(negedge clk);
        reset = 1'b1;

        runInstr(OP_ADD, 1'b0, 0);
        runInstr(OP_LW,  1'b0, 0);
        runInstr(OP_BEQ, 1'b1, 0);
        runInstr(OP_BEQ, 1'b0, 0);
        runInstr(OP_SW,  1'b0, 0);
        runInstr(OP_NOP, 1'b0, 0);
        runInstr(OP_J,   1'b0, 0);
        runInstr(OP_ADDI, 1'b1, 0);
        runInstr(OP_ORI, 1'b0, 0);
        runInstr(OP_SUB, 1'b0, 0);
        runInstr(OP_AND, 1'b0, 0);
        runInstr(OP_OR,  1'b0, 0);
        check("count_after_mix", 32'(instr_count), 32'd12);

        // Drive the counter to all-ones, then one more retirement wraps it.
        while (expCount != '1) runInstr(OP_NOP, 1'b0, 0);
        check("count_full", 32'(instr_count), 32'(CW'('1)));
        runInstr(OP_NOP, 1'b0, 0);
        check("count_wrap", 32'(instr_count), 32'd0);

        // Abort an add while it sits in WB_AL.
        runInstr(OP_ADD, 1'b0, 4);
        #2;
        reset = 1'b0;
        #1;
        checkResetState("rst_wbal");
        expCount = '0;
        @(negedge clk);
        reset = 1'b1;

        runInstr(OP_ADD, 1'b0, 0);
        runInstr(OP_HALT, 1'b0, 0);
        check("halt_state", 32'(state), 32'd8);
        check("halt_count", 32'(instr_count), 32'd1);
        reset = 1'b0;
        #1;
        checkResetState("rst_halt");
        expCount = '0;
        @(negedge clk);
        reset = 1'b1;
        runInstr(OP_J, 1'b0, 0);
        check("count_after_halt", 32'(instr_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Sequencing controller that turns the existing single-cycle datapath (PC, instruction ROM, register file, ALU, data RAM, extenders, selectors) into a multi-cycle machine. It replaces the combinational control unit, plus an added instruction register (IR) write enable. It walks each instruction through IF/ID/EXE/MEM/WB states and asserts write strobes only in the state where the write commits. Steering signals are decoded from the opcode held in the IR. It also counts retired instructions.

## Interface
- `CNT_W`, default 16, width of the retired-instruction counter.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]; stable from ID onward.
- `zero` input 1: ALU zero flag.
- `IRWre` output 1: IR load enable.
- `PCWre` output 1: PC update enable.
- `PCSrc` output 2: next-PC select; 00 = PC+4, 01 = PC+4+(ext<<2), 10 = jump target.
- `RegWre` output 1: register-file write enable.
- `DataMemRW` output 1: data RAM write (1 = write).
- `ALUOp` output 3: ALU operation; 000 = add, 001 = sub, 010 = or, 011 = and.
- `ALUSrcB` output 1: 1 selects immediate for ALU B.
- `ExtSel` output 1: 1 selects sign extension, 0 selects zero extension.
- `RegOut` output 1: 1 selects rd, 0 selects rt.
- `ALUM2Reg` output 1: 1 selects data RAM output as write-back data.
- `state` output 4: current state encoding (debug).
- `halted` output 1: high in HALT.
- `instr_count` output CNT_W: retired-instruction count.

## Operation
- Opcode map:
  - add 000000: R-type, ALUOp 000.
  - sub 000001: R-type, ALUOp 001.
  - and 010001: R-type, ALUOp 011.
  - or 010010: R-type, ALUOp 010.
  - addi 000010: ALUOp 000, ExtSel 1.
  - ori 010000: ALUOp 010, ExtSel 0.
  - sw 100110 and lw 100111: ALUOp 000, ExtSel 1, ALUSrcB 1.
  - beq 110000: ALUOp 001, ExtSel 1.
  - j 111000.
  - halt 111111.
  - Any other opcode is treated as a NOP.
- Steering outputs (ALUOp, ALUSrcB, ExtSel, RegOut, ALUM2Reg):
  - Combinational from `opcode` in every state except IF and HALT, where all of them are 0.
  - ALUSrcB = 1 for addi, ori, lw, sw.
  - RegOut = 1 for R-type only.
  - ALUM2Reg = 1 for lw only.
- States: IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_BR 0100, EXE_LS 0101, MEM 0110, WB_LD 0111, HALT 1000.
- Transitions:
  - IF → ID.
  - ID → EXE_AL for R-type, addi, ori.
  - ID → EXE_LS for lw, sw.
  - ID → EXE_BR for beq.
  - ID → IF for j and NOP.
  - ID → HALT for halt.
  - EXE_AL → WB_AL → IF.
  - EXE_BR → IF.
  - EXE_LS → MEM; MEM → IF for sw, MEM → WB_LD for lw; WB_LD → IF.
  - HALT → HALT until reset.
- Strobes (Moore outputs from state; PCSrc in EXE_BR also depends on `zero`); each is 0 in any state not listed:
  - IRWre = 1 in IF.
  - PCWre = 1 in the final state of each instruction:
    - ID for j and NOP (PCSrc 10 for j, 00 for NOP).
    - WB_AL.
    - EXE_BR, with PCSrc = {0, zero}.
    - MEM for sw.
    - WB_LD.
  - RegWre = 1 in WB_AL and WB_LD.
  - DataMemRW = 1 in MEM for sw.
  - PCSrc = 00 in every state not listed above.
- `instr_count` increments by 1 on every clock edge where PCWre = 1, and wraps from all-ones to 0. It does not count while halted.

## Timing
- Reset asserted (reset = 0):
  - State goes to IF immediately.
  - IRWre = 1.
  - All other strobes 0, PCSrc 00, steering 0, halted 0, instr_count 0.
- Release of reset: the first edge with reset = 1 leaves IF.
- Cycles per instruction: j/NOP 2, beq 3, R-type/addi/ori 4, sw 4, lw 5.
- IR captures the instruction at the IF→ID edge. `opcode` is valid from the first ID cycle onward.
- PC and register-file writes commit on the edge that ends the state asserting the strobe. The next IF fetches the updated PC.
- `zero` is evaluated combinationally in EXE_BR. The ALU result must settle within that cycle.
- Reset mid-instruction aborts it: no strobe fires after the asynchronous assertion, and instr_count clears.
- Opcode changes outside IF never alter the state path; the IR holds it stable.

## Test plan
- Reset with opcode = add, then release reset → state sequence 0000, 0001, 0010, 0011, 0000. RegWre = 1 only in 0011. PCWre = 1 only in 0011. RegOut = 1. instr_count = 1.
- lw (100111) → 5 cycles. ALUSrcB = 1, ExtSel = 1 from ID. ALUM2Reg = 1. DataMemRW stays 0. RegWre pulses in WB_LD only. instr_count increments once.
- beq with zero = 1, then beq with zero = 0 → EXE_BR has PCWre = 1 with PCSrc = 01, then PCSrc = 00. Each takes 3 cycles. ALUOp = 001.
- sw, then unknown opcode 101010, then j → sw: DataMemRW = 1 in MEM only. NOP: 2 cycles, PCSrc 00. j: 2 cycles, PCSrc 10 in ID. instr_count advances by 3.
- halt → state 1000, halted = 1, all strobes 0 for 50 cycles, instr_count frozen. Asserting reset returns to IF with halted = 0.
- Preload instr_count to 0xFFFF via 65535 NOP retirements, then one more → wraps to 0x0000. Asserting reset during WB_AL → RegWre drops immediately and state = 0000.
